restock_controller: RTL and testbench

Owns the physical stock of the three dispenser tanks (water, juice, chemical). It is the writer/replenisher for the stock that fluid_dispenser reads as remaining_qty. It accepts dispense draws and debits the tanks, flagging any tank that runs low or rejects a draw. It then runs a request/ack handshake with the external supplier and refills the flagged tank at a fixed rate up to capacity.

---
 rtl/fluid_pkg.sv | 29 ++
 rtl/tank_level.sv | 49 ++++
 rtl/restock_controller.sv | 141 ++++++++++++++
 tb/tb_restock_controller.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fluid_pkg.sv
// Shared types for the dispenser tank stock: fluid codes, datapath widths,
// restock FSM states and the restock arbitration helper.
package fluid_pkg;

  localparam int unsigned LEVEL_W = 16;
  localparam int unsigned VOL_W   = 8;

  typedef enum logic [1:0] {
    FLUID_WATER   = 2'b00,
    FLUID_JUICE   = 2'b01,
    FLUID_CHEM    = 2'b10,
    FLUID_INVALID = 2'b11
  } fluid_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FILL,
    DONE
  } state_t;

  // Fixed priority: water before juice before chemical.
  function automatic fluid_t lowest_pending(input logic [2:0] pending);
    if (pending[0])      return FLUID_WATER;
    else if (pending[1]) return FLUID_JUICE;
    else                 return FLUID_CHEM;
  endfunction

endpackage

// File: rtl/tank_level.sv
// One tank: level register, draw accept/debit, saturating fill and low-mark flag.
module tank_level
  import fluid_pkg::*;
#(
  parameter int unsigned CAPACITY   = 100,
  parameter int unsigned LOW_MARK   = 20,
  parameter int unsigned FILL_RATE  = 5,
  parameter int unsigned INIT_LEVEL = 50
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               draw,
  input  logic [VOL_W-1:0]   volume,
  input  logic               fill_en,
  output logic [LEVEL_W-1:0] level,
  output logic               accept,
  output logic [LEVEL_W-1:0] next_level,
  output logic               low
);

  localparam logic [LEVEL_W-1:0] CAP_L  = LEVEL_W'(CAPACITY);
  localparam logic [LEVEL_W-1:0] LOW_L  = LEVEL_W'(LOW_MARK);
  localparam logic [LEVEL_W-1:0] RATE_L = LEVEL_W'(FILL_RATE);
  localparam logic [LEVEL_W-1:0] INIT_L = LEVEL_W'(INIT_LEVEL);

  logic [LEVEL_W-1:0] vol_ext;
  logic [LEVEL_W-1:0] post_draw;
  logic [LEVEL_W-1:0] headroom;
  logic [LEVEL_W-1:0] fill_amt;

  // Accept is judged on the pre-update level; the fill is clamped
  // against the post-draw level so a same-cycle draw+fill never overshoots.
  always_comb begin
    vol_ext   = LEVEL_W'(volume);
    accept    = draw && (volume != '0) && (vol_ext <= level);
    post_draw = accept ? (level - vol_ext) : level;
    headroom  = CAP_L - post_draw;
    fill_amt  = '0;
    if (fill_en) fill_amt = (headroom < RATE_L) ? headroom : RATE_L;
    next_level = post_draw + fill_amt;
    low        = next_level < LOW_L;
  end

  always_ff @(posedge clk) begin
    if (reset) level <= INIT_L;
    else       level <= next_level;
  end

endmodule

// File: rtl/restock_controller.sv
// Owns the three tank levels, debits dispense draws and runs the supplier
// request/ack handshake that refills flagged tanks up to capacity.
module restock_controller
  import fluid_pkg::*;
#(
  parameter int unsigned CAPACITY    = 100,
  parameter int unsigned LOW_MARK    = 20,
  parameter int unsigned FILL_RATE   = 5,
  parameter int unsigned ACK_TIMEOUT = 15,
  parameter int unsigned INIT_LEVEL  = 50
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               disp_valid,
  input  logic [1:0]         disp_fluid,
  input  logic [VOL_W-1:0]   disp_volume,
  output logic               disp_ok,
  output logic               disp_reject,
  output logic [LEVEL_W-1:0] level_water,
  output logic [LEVEL_W-1:0] level_juice,
  output logic [LEVEL_W-1:0] level_chem,
  output logic               sup_req,
  output logic [1:0]         sup_fluid,
  input  logic               sup_ack,
  output logic               fill_active,
  output logic               restock_done,
  output logic               timeout_err
);

  localparam int unsigned        TIMER_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(ACK_TIMEOUT - 1);
  localparam logic [LEVEL_W-1:0] CAP_L = LEVEL_W'(CAPACITY);

  state_t             state, state_next;
  fluid_t             sel, sel_next;
  logic [TIMER_W-1:0] timer, timer_next;
  logic               timeout_hit;
  logic [2:0]         pending, pending_next;

  logic [2:0]         draw, fill_en, accept, low;
  logic [LEVEL_W-1:0] level [3];
  logic [LEVEL_W-1:0] next_level [3];

  always_comb begin
    draw    = '0;
    fill_en = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      draw[i]    = disp_valid && (disp_fluid == i[1:0]);
      fill_en[i] = (state == FILL) && (sel == i[1:0]);
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_tank
    tank_level #(
      .CAPACITY  (CAPACITY),
      .LOW_MARK  (LOW_MARK),
      .FILL_RATE (FILL_RATE),
      .INIT_LEVEL(INIT_LEVEL)
    ) u_tank (
      .clk       (clk),
      .reset     (reset),
      .draw      (draw[g]),
      .volume    (disp_volume),
      .fill_en   (fill_en[g]),
      .level     (level[g]),
      .accept    (accept[g]),
      .next_level(next_level[g]),
      .low       (low[g])
    );
  end

  assign level_water = level[0];
  assign level_juice = level[1];
  assign level_chem  = level[2];

  // DONE clears first so that a same-cycle reject or low level re-arms the bit.
  always_comb begin
    pending_next = pending;
    if (state == DONE) pending_next[sel] = 1'b0;
    pending_next = pending_next | (draw & ~accept) | low;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      sel         <= FLUID_WATER;
      timer       <= '0;
      pending     <= '0;
      timeout_err <= 1'b0;
      disp_ok     <= 1'b0;
      disp_reject <= 1'b0;
    end else begin
      state       <= state_next;
      sel         <= sel_next;
      timer       <= timer_next;
      pending     <= pending_next;
      timeout_err <= timeout_err | timeout_hit;
      disp_ok     <= disp_valid && (|accept);
      disp_reject <= disp_valid && !(|accept);
    end
  end

  always_comb begin
    state_next  = state;
    sel_next    = sel;
    timer_next  = timer;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (|pending) begin
          sel_next   = lowest_pending(pending);
          timer_next = '0;
          state_next = REQ;
        end
      end
      REQ: begin
        if (sup_ack) begin
          timer_next = '0;
          state_next = FILL;
        end else if (timer == TIMER_LAST) begin
          timeout_hit = 1'b1;
          timer_next  = '0;
          state_next  = IDLE;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      FILL:    if (next_level[sel] == CAP_L) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sup_req      = (state == REQ);
    fill_active  = (state == FILL);
    restock_done = (state == DONE);
    sup_fluid    = ((state == REQ) || (state == FILL)) ? sel : FLUID_WATER;
  end

endmodule

// File: tb/tb_restock_controller.sv
// Self-checking bench for restock_controller: table-driven draws plus
// hand-written restock, timeout and mid-fill sequences.
module tb_restock_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        disp_valid;
  logic [1:0]  disp_fluid;
  logic [7:0]  disp_volume;
  logic        disp_ok, disp_reject;
  logic [15:0] level_water, level_juice, level_chem;
  logic        sup_req;
  logic [1:0]  sup_fluid;
  logic        sup_ack;
  logic        fill_active, restock_done, timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  restock_controller #(
    .CAPACITY   (100),
    .LOW_MARK   (20),
    .FILL_RATE  (5),
    .ACK_TIMEOUT(15),
    .INIT_LEVEL (50)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .disp_valid  (disp_valid),
    .disp_fluid  (disp_fluid),
    .disp_volume (disp_volume),
    .disp_ok     (disp_ok),
    .disp_reject (disp_reject),
    .level_water (level_water),
    .level_juice (level_juice),
    .level_chem  (level_chem),
    .sup_req     (sup_req),
    .sup_fluid   (sup_fluid),
    .sup_ack     (sup_ack),
    .fill_active (fill_active),
    .restock_done(restock_done),
    .timeout_err (timeout_err)
  );

  typedef struct {
    bit          ok;
    bit          rej;
    bit          lvl;
    logic [15:0] w, j, c;
  } exp_t;

  typedef struct {
    logic        v;
    logic [1:0]  f;
    logic [7:0]  vol;
    bit          ok;
    bit          rej;
    logic [15:0] w, j, c;
  } vec_t;

  exp_t sb[$];
  vec_t vt[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] f, input logic [7:0] vol,
                       input bit ok, input bit rej, input bit lvl,
                       input logic [15:0] w, input logic [15:0] j, input logic [15:0] c);
    exp_t e;
    disp_valid  = v;
    disp_fluid  = f;
    disp_volume = vol;
    e.ok = ok; e.rej = rej; e.lvl = lvl; e.w = w; e.j = j; e.c = c;
    sb.push_back(e);
  endtask

  // One clock: results of the previous drive are popped and compared.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    disp_valid  = 1'b0;
    disp_fluid  = 2'b00;
    disp_volume = 8'd0;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("disp_ok", disp_ok, e.ok);
      check("disp_reject", disp_reject, e.rej);
      if (e.lvl) begin
        check("level_water", level_water, e.w);
        check("level_juice", level_juice, e.j);
        check("level_chem", level_chem, e.c);
      end
    end else begin
      check("idle_pulses", {disp_ok, disp_reject}, 2'b00);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;

    vt[0] = '{1'b1, 2'd0, 8'd1,  1'b1, 1'b0, 16'd49, 16'd50, 16'd50};
    vt[1] = '{1'b1, 2'd3, 8'd5,  1'b0, 1'b1, 16'd49, 16'd50, 16'd50};
    vt[2] = '{1'b1, 2'd1, 8'd10, 1'b1, 1'b0, 16'd49, 16'd40, 16'd50};
    vt[3] = '{1'b1, 2'd2, 8'd25, 1'b1, 1'b0, 16'd49, 16'd40, 16'd25};
    vt[4] = '{1'b0, 2'd0, 8'd0,  1'b0, 1'b0, 16'd49, 16'd40, 16'd25};
    vt[5] = '{1'b1, 2'd1, 8'd20, 1'b1, 1'b0, 16'd49, 16'd20, 16'd25};
    vt[6] = '{1'b1, 2'd0, 8'd29, 1'b1, 1'b0, 16'd20, 16'd20, 16'd25};
    vt[7] = '{1'b1, 2'd3, 8'd0,  1'b0, 1'b1, 16'd20, 16'd20, 16'd25};
    vt[8] = '{1'b1, 2'd2, 8'd5,  1'b1, 1'b0, 16'd20, 16'd20, 16'd20};

    reset = 1'b1; disp_valid = 1'b0; disp_fluid = 2'b00; disp_volume = 8'd0; sup_ack = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // Reset state, idle, and a stray ack outside REQ
    repeat (3) tick();
    check("rst_level_water", level_water, 50);
    check("rst_level_juice", level_juice, 50);
    check("rst_level_chem", level_chem, 50);
    check("rst_sup_req", sup_req, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_fill_active", fill_active, 0);
    check("rst_restock_done", restock_done, 0);
    sup_ack = 1'b1;
    tick(); tick();
    sup_ack = 1'b0;
    check("stray_ack_fill_active", fill_active, 0);
    check("stray_ack_sup_req", sup_req, 0);

    // Table of draws; every level ends exactly at the low mark
    for (int i = 0; i < 9; i++) begin
      drive(vt[i].v, vt[i].f, vt[i].vol, vt[i].ok, vt[i].rej, 1'b1, vt[i].w, vt[i].j, vt[i].c);
      tick();
    end
    tick(); tick();
    check("at_low_mark_no_req", sup_req, 0);

    // Over-level draw on a valid fluid is refused and requests restock
    drive(1'b1, 2'd2, 8'd21, 1'b0, 1'b1, 1'b1, 16'd20, 16'd20, 16'd20);
    tick();
    check("reject_req_latency", sup_req, 0);
    tick();
    check("reject_sup_req", sup_req, 1);
    check("reject_sup_fluid", sup_fluid, 2);

    // Chemical restock after a refused 70 L draw
    do_reset();
    drive(1'b1, 2'd2, 8'd70, 1'b0, 1'b1, 1'b1, 16'd50, 16'd50, 16'd50);
    tick();
    check("chem_req_latency", sup_req, 0);
    tick();
    check("chem_sup_req", sup_req, 1);
    check("chem_sup_fluid", sup_fluid, 2);
    tick(); tick();
    sup_ack = 1'b1;
    tick();
    sup_ack = 1'b0;
    check("chem_fill_active", fill_active, 1);
    check("chem_fill_sup_req", sup_req, 0);
    check("chem_fill_sup_fluid", sup_fluid, 2);
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("chem_fill_level", level_chem, 50 + 5 * k);
      check("chem_fill_active_k", fill_active, (k < 10) ? 1 : 0);
      check("chem_restock_done_k", restock_done, (k == 10) ? 1 : 0);
    end
    tick();
    check("chem_done_pulse_end", restock_done, 0);
    tick();
    check("chem_pending_cleared", sup_req, 0);
    check("chem_level_final", level_chem, 100);

    // Juice drops below the low mark, then the ack times out
    drive(1'b1, 2'd1, 8'd31, 1'b1, 1'b0, 1'b1, 16'd50, 16'd19, 16'd100);
    tick();
    tick();
    check("juice_sup_req", sup_req, 1);
    check("juice_sup_fluid", sup_fluid, 1);
    cnt = 1;
    drive(1'b1, 2'd3, 8'd5, 1'b0, 1'b1, 1'b1, 16'd50, 16'd19, 16'd100);
    tick();
    if (sup_req) cnt++;
    drive(1'b1, 2'd1, 8'd0, 1'b0, 1'b1, 1'b1, 16'd50, 16'd19, 16'd100);
    tick();
    if (sup_req) cnt++;
    for (int i = 0; i < 40 && sup_req; i++) begin
      tick();
      if (sup_req) cnt++;
    end
    check("timeout_req_cycles", cnt, 15);
    check("timeout_err_set", timeout_err, 1);
    for (int i = 0; i < 5 && !sup_req; i++) tick();
    check("retry_sup_req", sup_req, 1);
    check("retry_sup_fluid", sup_fluid, 1);
    check("timeout_err_sticky", timeout_err, 1);
    sup_ack = 1'b1;
    tick();
    sup_ack = 1'b0;
    cnt = fill_active ? 1 : 0;
    for (int i = 0; i < 30 && !restock_done; i++) begin
      tick();
      if (fill_active) cnt++;
    end
    check("juice_done_pulse", restock_done, 1);
    check("juice_fill_cycles", cnt, 17);
    check("juice_level_full", level_juice, 100);
    check("timeout_err_after_fill", timeout_err, 1);

    // Same-tank draw during a water fill, then reset mid-fill
    do_reset();
    check("reset_clears_timeout", timeout_err, 0);
    drive(1'b1, 2'd0, 8'd33, 1'b1, 1'b0, 1'b1, 16'd17, 16'd50, 16'd50);
    tick();
    for (int i = 0; i < 3 && !sup_req; i++) tick();
    check("water_sup_req", sup_req, 1);
    check("water_sup_fluid", sup_fluid, 0);
    sup_ack = 1'b1;
    tick();
    sup_ack = 1'b0;
    for (int i = 0; i < 30 && level_water != 16'd97; i++) tick();
    check("water_reach_97", level_water, 97);
    check("water_fill_at_97", fill_active, 1);
    drive(1'b1, 2'd0, 8'd10, 1'b1, 1'b0, 1'b1, 16'd92, 16'd50, 16'd50);
    tick();
    check("draw_fill_continues", fill_active, 1);
    tick();
    check("draw_fill_next_level", level_water, 97);
    reset = 1'b1;
    tick();
    check("midfill_rst_water", level_water, 50);
    check("midfill_rst_juice", level_juice, 50);
    check("midfill_rst_chem", level_chem, 50);
    check("midfill_rst_fill_active", fill_active, 0);
    check("midfill_rst_done", restock_done, 0);
    check("midfill_rst_sup_req", sup_req, 0);
    reset = 1'b0;
    tick();
    check("post_rst_done", restock_done, 0);
    check("post_rst_fill_active", fill_active, 0);
    check("post_rst_sup_req", sup_req, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
